// File: rtl/mdbrot_pkg.sv
// mdbrot_pkg: shared screen geometry, scheduler states and the iteration-to-colour map
package mdbrot_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} sched_state_t;
  function automatic logic [2:0] iter_to_colour(input logic [31:0] iter, input logic [31:0] max_iter);
    return iter >= max_iter ? 3'b000 : iter[2:0] == 3'b000 ? 3'b111 : iter[2:0];
  endfunction
endpackage

// File: rtl/mdbrot_rr_arbiter.sv
// mdbrot_rr_arbiter: one-hot round-robin grant whose priority starts just past the last winner
module mdbrot_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);
  localparam int PW = N > 1 ? $clog2(N) : 1;
  logic [PW-1:0] last, win;
  // Scan from the furthest offset down so the nearest requester after last wins
  always_comb begin
    grant = '0;
    win = last;
    for (int k = N; k >= 1; k--)
      for (int j = 0; j < N; j++)
        if (req[j] && j == (int'(last) + k) % N) begin
          grant = '0;
          grant[j] = 1'b1;
          win = PW'(j);
        end
  end
  always_ff @(posedge clk)
    if (!rst_n) last <= PW'(N - 1);
    else if (|grant) last <= win;
endmodule

// File: rtl/mdbrot_core_scheduler.sv
// mdbrot_core_scheduler: raster-order pixel dispatch to escape-time cores and
// round-robin retirement of their results onto the VGA plot port
module mdbrot_core_scheduler
  import mdbrot_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ITER_W    = 13
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [ITER_W-1:0]           max_iter,
  output logic                        done,
  output logic [NUM_CORES-1:0]        core_start,
  output logic [7:0]                  core_x,
  output logic [6:0]                  core_y,
  output logic [ITER_W-1:0]           core_max_iter,
  input  logic [NUM_CORES-1:0]        core_done,
  input  logic [NUM_CORES*ITER_W-1:0] core_iter,
  output logic [NUM_CORES-1:0]        core_ack,
  output logic [7:0]                  vga_x,
  output logic [6:0]                  vga_y,
  output logic [2:0]                  vga_colour,
  output logic                        vga_plot
);
  localparam logic [7:0] LAST_X = 8'(SCREEN_W - 1);
  localparam logic [6:0] LAST_Y = 7'(SCREEN_H - 1);
  sched_state_t state, state_nx;
  logic start_q, last_px;
  logic [7:0] ptr_x, sel_x;
  logic [6:0] ptr_y, sel_y;
  logic [NUM_CORES-1:0] busy, free, grant;
  logic [7:0] tag_x [NUM_CORES];
  logic [6:0] tag_y [NUM_CORES];
  logic [ITER_W-1:0] max_iter_q, sel_iter;
  assign free = ~busy;
  assign core_start = state == RUN ? free & (~free + NUM_CORES'(1)) : '0;
  assign core_x = ptr_x;
  assign core_y = ptr_y;
  assign core_max_iter = max_iter_q;
  assign core_ack = grant;
  assign last_px = ptr_x == LAST_X && ptr_y == LAST_Y;
  // busy gates the requests, so done from an idle core never wins a grant
  mdbrot_rr_arbiter #(.N(NUM_CORES)) u_arb (
    .clk(clk),
    .rst_n(rst_n),
    .req(core_done & busy),
    .grant(grant)
  );
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    sel_iter = '0;
    for (int i = 0; i < NUM_CORES; i++)
      if (grant[i]) begin
        sel_x = tag_x[i];
        sel_y = tag_y[i];
        sel_iter = core_iter[i*ITER_W +: ITER_W];
      end
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start && !start_q) state_nx = RUN;
      RUN:     if (|core_start && last_px) state_nx = DRAIN;
      DRAIN:   if (busy == '0 && !vga_plot) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      start_q <= 1'b0;
      ptr_x <= '0;
      ptr_y <= '0;
      busy <= '0;
      max_iter_q <= '0;
      done <= 1'b0;
      vga_plot <= 1'b0;
      vga_x <= '0;
      vga_y <= '0;
      vga_colour <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        tag_x[i] <= '0;
        tag_y[i] <= '0;
      end
    end else begin
      state <= state_nx;
      start_q <= start;
      busy <= (busy | core_start) & ~grant;
      vga_plot <= |grant;
      vga_x <= sel_x;
      vga_y <= sel_y;
      vga_colour <= |grant ? iter_to_colour(32'(sel_iter), 32'(max_iter_q)) : 3'b000;
      if (state == IDLE && state_nx == RUN) begin
        max_iter_q <= max_iter;
        ptr_x <= '0;
        ptr_y <= '0;
        done <= 1'b0;
      end
      if (state == FIN) done <= 1'b1;
      if (|core_start) begin
        ptr_x <= ptr_x == LAST_X ? 8'd0 : ptr_x + 8'd1;
        ptr_y <= ptr_x == LAST_X ? ptr_y + 7'd1 : ptr_y;
      end
      for (int i = 0; i < NUM_CORES; i++)
        if (core_start[i]) begin
          tag_x[i] <= ptr_x;
          tag_y[i] <= ptr_y;
        end
    end
  end
endmodule
